// File: rtl/acq_ctrl.sv
// Acquisition command sequencer: filters UART commands, owns rate/point config,
// generates sample strobes and issues TX responses. Optional: ACQ_CTRL_CONTINUOUS_EN.
module acq_ctrl #(
  parameter logic [7:0]  MY_ADDR    = 8'h01,
  parameter logic [15:0] DEF_RATE   = 16'd100,
  parameter logic [15:0] DEF_POINTS = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_en,
  input  logic [2:0]  i_func,
  input  logic [7:0]  i_addr,
  input  logic [15:0] i_rate_conf,
  input  logic        i_rate_conf_en,
  input  logic [15:0] i_point_conf,
  input  logic        i_point_conf_en,
  input  logic        i_tx_ack,
  output logic        o_sample_tick,
  output logic [15:0] o_sample_idx,
  output logic        o_done,
  output logic [1:0]  o_state,
  output logic        o_tx_req,
  output logic [2:0]  o_tx_type,
  output logic [15:0] o_tx_arg,
  output logic        o_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F_START = 3'd1;
  localparam logic [2:0] F_STOP  = 3'd2;
  localparam logic [2:0] F_DATA  = 3'd3;
  localparam logic [2:0] F_ADDR  = 3'd4;
  localparam logic [2:0] F_STATE = 3'd5;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_rate, r_points, r_rate_cnt, r_count, r_idx;
  logic        r_tick, r_done, r_err;
  logic        r_tx_req;
  logic [2:0]  r_tx_type;
  logic [15:0] r_tx_arg;

  logic w_cmd_ok, w_start, w_stop, w_resp, w_run, w_wrap, w_stop_run;
  logic w_tick, w_last, w_start_ok, w_tx_busy, w_data_ok, w_resp_ok;
  logic w_rate_err, w_point_err, w_err, w_data_ack;

  always_comb begin
    w_cmd_ok    = i_cmd_en && ((i_addr == MY_ADDR) || (i_addr == 8'hFF));
    w_start     = w_cmd_ok && (i_func == F_START);
    w_stop      = w_cmd_ok && (i_func == F_STOP);
    w_resp      = w_cmd_ok && ((i_func == F_DATA) || (i_func == F_ADDR) || (i_func == F_STATE));
    w_run       = (r_state == ST_RUN);
    w_wrap      = w_run && (r_rate_cnt == r_rate - 16'd1);
    w_stop_run  = w_stop && w_run;
    // A STOP landing on a wrap cycle swallows that tick (and any done with it).
    w_tick      = w_wrap && !w_stop_run;
    w_last      = w_tick && (r_count == r_points - 16'd1);
    w_start_ok  = w_start && !w_run;
    w_tx_busy   = r_tx_req && !i_tx_ack;
`ifdef ACQ_CTRL_CONTINUOUS_EN
    w_data_ok   = 1'b0;
`else
    w_data_ok   = (r_state == ST_DONE);
`endif
    w_resp_ok   = w_resp && !w_tx_busy && ((i_func != F_DATA) || w_data_ok);
    w_rate_err  = i_rate_conf_en  && (w_run || (i_rate_conf  == 16'd0));
    w_point_err = i_point_conf_en && (w_run || (i_point_conf == 16'd0));
    w_err       = w_rate_err || w_point_err || (w_start && w_run) || (w_resp && !w_resp_ok);
    w_data_ack  = r_tx_req && i_tx_ack && (r_tx_type == F_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_stop) w_state_nxt = ST_IDLE;
`ifdef ACQ_CTRL_CONTINUOUS_EN
        else if (w_last) w_state_nxt = ST_RUN;
`else
        else if (w_last) w_state_nxt = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (w_start)         w_state_nxt = ST_RUN;
        else if (w_data_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all state, config included, is async-reset so a mid-run reset is immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate     <= DEF_RATE;
      r_points   <= DEF_POINTS;
      r_rate_cnt <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_tx_req   <= 1'b0;
      r_tx_type  <= '0;
      r_tx_arg   <= '0;
    end else begin
      r_tick <= w_tick;
      r_done <= w_last;
      r_err  <= w_err;

      if (i_rate_conf_en  && !w_rate_err)  r_rate   <= i_rate_conf;
      if (i_point_conf_en && !w_point_err) r_points <= i_point_conf;

      if (w_start_ok) begin
        r_rate_cnt <= '0;
        r_count    <= '0;
      end else if (w_run && !w_stop) begin
        r_rate_cnt <= w_wrap ? 16'd0 : r_rate_cnt + 16'd1;
        if (w_tick) begin
          r_idx   <= r_count;
          r_count <= w_last ? 16'd0 : r_count + 16'd1;
        end
      end

      // A same-cycle ack frees the slot, so the new request simply replaces the old one.
      if (w_resp_ok) begin
        r_tx_req  <= 1'b1;
        r_tx_type <= i_func;
        unique case (i_func)
          F_ADDR:  r_tx_arg <= {8'h00, MY_ADDR};
          F_STATE: r_tx_arg <= {14'b0, r_state};
          default: r_tx_arg <= r_points;
        endcase
      end else if (i_tx_ack) begin
        r_tx_req <= 1'b0;
      end
    end
  end

  always_comb begin
    o_state       = r_state;
    o_sample_tick = r_tick;
    o_sample_idx  = r_idx;
    o_done        = r_done;
    o_err         = r_err;
    o_tx_req      = r_tx_req;
    o_tx_type     = r_tx_type;
    o_tx_arg      = r_tx_arg;
  end

endmodule

// File: tb/tb_acq_ctrl.sv
// Directed self-checking bench for acq_ctrl (default build, single-shot mode).
module tb_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cmd_en, i_rate_conf_en, i_point_conf_en, i_tx_ack;
  logic [2:0]  i_func;
  logic [7:0]  i_addr;
  logic [15:0] i_rate_conf, i_point_conf;
  logic        o_sample_tick, o_done, o_tx_req, o_err;
  logic [15:0] o_sample_idx, o_tx_arg;
  logic [1:0]  o_state;
  logic [2:0]  o_tx_type;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  acq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_en(i_cmd_en), .i_func(i_func), .i_addr(i_addr),
    .i_rate_conf(i_rate_conf), .i_rate_conf_en(i_rate_conf_en),
    .i_point_conf(i_point_conf), .i_point_conf_en(i_point_conf_en),
    .i_tx_ack(i_tx_ack),
    .o_sample_tick(o_sample_tick), .o_sample_idx(o_sample_idx), .o_done(o_done),
    .o_state(o_state), .o_tx_req(o_tx_req), .o_tx_type(o_tx_type),
    .o_tx_arg(o_tx_arg), .o_err(o_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] f, input logic [7:0] a);
    i_cmd_en = 1'b1; i_func = f; i_addr = a;
    step();
    i_cmd_en = 1'b0; i_func = 3'd0; i_addr = 8'd0;
  endtask

  task automatic ack();
    i_tx_ack = 1'b1;
    step();
    i_tx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_cmd_en = 0; i_func = 0; i_addr = 0; i_tx_ack = 0;
    i_rate_conf = 0; i_rate_conf_en = 0; i_point_conf = 0; i_point_conf_en = 0;
    #12;
    total_cnt++;
    if ({o_sample_tick, o_sample_idx, o_done, o_state, o_tx_req, o_tx_type, o_tx_arg, o_err} !== '0)
      $display("FAIL reset_outputs: got state=%0d req=%0b idx=%0d arg=%0h err=%0b, expected all 0",
               o_state, o_tx_req, o_sample_idx, o_tx_arg, o_err);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_state_query();
    send_cmd(3'd5, 8'h01);
    total_cnt++;
    if ({o_tx_req, o_tx_type, o_tx_arg} !== {1'b1, 3'd5, 16'h0000})
      $display("FAIL state_query: got req=%0b type=%0d arg=%0h, expected req=1 type=5 arg=0",
               o_tx_req, o_tx_type, o_tx_arg);
    else pass_cnt++;
    ack();
    total_cnt++;
    if (o_tx_req !== 1'b0) $display("FAIL state_query_ack: got req=%0b, expected 0", o_tx_req);
    else pass_cnt++;
  endtask

  task automatic test_acquisition();
    int tick_at[3];
    int n_ticks = 0;
    int done_at = -1;
    logic [15:0] idx_at[3];
    i_rate_conf = 16'd4; i_rate_conf_en = 1'b1;
    i_point_conf = 16'd3; i_point_conf_en = 1'b1;
    step();
    i_rate_conf_en = 1'b0; i_point_conf_en = 1'b0;
    step();
    total_cnt++;
    if (o_err !== 1'b0) $display("FAIL dual_conf: got err=%0b, expected 0", o_err);
    else pass_cnt++;
    send_cmd(3'd1, 8'h01);
    total_cnt++;
    if (o_state !== 2'd1) $display("FAIL start_state: got %0d, expected 1", o_state);
    else pass_cnt++;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (o_sample_tick) begin
        if (n_ticks < 3) begin tick_at[n_ticks] = k; idx_at[n_ticks] = o_sample_idx; end
        n_ticks++;
      end
      if (o_done) done_at = k;
    end
    total_cnt++;
    if (n_ticks !== 3) $display("FAIL tick_count: got %0d, expected 3", n_ticks);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (n_ticks >= i + 1 && tick_at[i] == 4 * (i + 1) && idx_at[i] == 16'(i)) pass_cnt++;
      else $display("FAIL tick_%0d: got cycle=%0d idx=%0d, expected cycle=%0d idx=%0d",
                    i, tick_at[i], idx_at[i], 4 * (i + 1), i);
    end
    total_cnt++;
    if (done_at != 12) $display("FAIL done_cycle: got %0d, expected 12", done_at);
    else pass_cnt++;
    total_cnt++;
    if (o_state !== 2'd2) $display("FAIL done_state: got %0d, expected 2", o_state);
    else pass_cnt++;
  endtask

  task automatic test_data_return();
    send_cmd(3'd3, 8'h01);
    total_cnt++;
    if ({o_tx_req, o_tx_type, o_tx_arg} !== {1'b1, 3'd3, 16'd3})
      $display("FAIL data_return: got req=%0b type=%0d arg=%0h, expected req=1 type=3 arg=3",
               o_tx_req, o_tx_type, o_tx_arg);
    else pass_cnt++;
    ack();
    total_cnt++;
    if ({o_tx_req, o_state} !== {1'b0, 2'd0})
      $display("FAIL data_return_ack: got req=%0b state=%0d, expected req=0 state=0", o_tx_req, o_state);
    else pass_cnt++;
    send_cmd(3'd3, 8'h01);
    total_cnt++;
    if ({o_err, o_tx_req} !== 2'b10)
      $display("FAIL data_return_idle: got err=%0b req=%0b, expected err=1 req=0", o_err, o_tx_req);
    else pass_cnt++;
  endtask

  task automatic test_run_conf_stop();
    int tick_at[2];
    int n_ticks = 0;
    int err_ok = 1;
    int done_seen = 0;
    send_cmd(3'd1, 8'hFF);
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) begin i_rate_conf = 16'd10; i_rate_conf_en = 1'b1; end
      if (k == 12) begin i_cmd_en = 1'b1; i_func = 3'd2; i_addr = 8'h01; end
      step();
      i_rate_conf_en = 1'b0; i_cmd_en = 1'b0; i_func = 3'd0; i_addr = 8'd0;
      if (o_sample_tick) begin
        if (n_ticks < 2) tick_at[n_ticks] = k;
        n_ticks++;
      end
      if (o_err !== (k == 2)) err_ok = 0;
      if (o_done) done_seen = 1;
    end
    total_cnt++;
    if (err_ok != 1) $display("FAIL run_conf_err: o_err pulse not exactly at cycle 2");
    else pass_cnt++;
    total_cnt++;
    if (n_ticks == 2 && tick_at[0] == 4 && tick_at[1] == 8) pass_cnt++;
    else $display("FAIL stop_ticks: got %0d ticks first=%0d second=%0d, expected 2 at 4 and 8",
                  n_ticks, tick_at[0], tick_at[1]);
    total_cnt++;
    if ({o_state, o_sample_idx, 1'(done_seen)} !== {2'd0, 16'd1, 1'b0})
      $display("FAIL stop_state: got state=%0d idx=%0d done=%0d, expected state=0 idx=1 done=0",
               o_state, o_sample_idx, done_seen);
    else pass_cnt++;
  endtask

  task automatic test_addr();
    send_cmd(3'd5, 8'h22);
    total_cnt++;
    if ({o_tx_req, o_err} !== 2'b00)
      $display("FAIL foreign_addr: got req=%0b err=%0b, expected 0 0", o_tx_req, o_err);
    else pass_cnt++;
    send_cmd(3'd4, 8'hFF);
    total_cnt++;
    if ({o_tx_req, o_tx_type, o_tx_arg} !== {1'b1, 3'd4, 16'h0001})
      $display("FAIL addr_inq: got req=%0b type=%0d arg=%0h, expected req=1 type=4 arg=1",
               o_tx_req, o_tx_type, o_tx_arg);
    else pass_cnt++;
    send_cmd(3'd4, 8'h01);
    total_cnt++;
    if ({o_err, o_tx_req, o_tx_type} !== {1'b1, 1'b1, 3'd4})
      $display("FAIL busy_inq: got err=%0b req=%0b type=%0d, expected err=1 req=1 type=4",
               o_err, o_tx_req, o_tx_type);
    else pass_cnt++;
    i_tx_ack = 1'b1;
    send_cmd(3'd5, 8'h01);
    i_tx_ack = 1'b0;
    total_cnt++;
    if ({o_err, o_tx_req, o_tx_type, o_tx_arg} !== {1'b0, 1'b1, 3'd5, 16'd0})
      $display("FAIL ack_and_cmd: got err=%0b req=%0b type=%0d arg=%0h, expected err=0 req=1 type=5 arg=0",
               o_err, o_tx_req, o_tx_type, o_tx_arg);
    else pass_cnt++;
    ack();
  endtask

  task automatic test_zero_conf_and_reset();
    int first = -1;
    i_rate_conf = 16'd0; i_rate_conf_en = 1'b1;
    step();
    i_rate_conf_en = 1'b0;
    total_cnt++;
    if (o_err !== 1'b1) $display("FAIL zero_rate_err: got err=%0b, expected 1", o_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (o_err !== 1'b0) $display("FAIL err_pulse_width: got err=%0b, expected 0", o_err);
    else pass_cnt++;
    send_cmd(3'd1, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (o_sample_tick && first < 0) first = k;
    end
    total_cnt++;
    if (first != 4) $display("FAIL rate_kept: got first tick at %0d, expected 4", first);
    else pass_cnt++;
    send_cmd(3'd5, 8'h01);
    total_cnt++;
    if ({o_tx_req, o_tx_arg} !== {1'b1, 16'd1})
      $display("FAIL run_query: got req=%0b arg=%0h, expected req=1 arg=1", o_tx_req, o_tx_arg);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({o_sample_tick, o_sample_idx, o_done, o_state, o_tx_req, o_tx_type, o_tx_arg, o_err} !== '0)
      $display("FAIL async_reset: got state=%0d req=%0b idx=%0d arg=%0h, expected all 0",
               o_state, o_tx_req, o_sample_idx, o_tx_arg);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    step();
    send_cmd(3'd1, 8'h01);
    first = -1;
    for (int k = 1; k <= 150 && first < 0; k++) begin
      step();
      if (o_sample_tick) first = k;
    end
    total_cnt++;
    if (first != 100) $display("FAIL default_rate: got first tick at %0d, expected 100", first);
    else pass_cnt++;
    send_cmd(3'd2, 8'h01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_state_query();
    test_acquisition();
    test_data_return();
    test_run_conf_stop();
    test_addr();
    test_zero_conf_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/acq_ctrl.md
Name: acq_ctrl

Overview:
- Command sequencer between the UART command decoder and the ADC sampling engine / response transmitter.
- Consumes decoded command pulses (function code, address, rate/point configuration).
- Owns the sampling-rate and sampling-point registers, generates the per-sample strobe stream, and tracks acquisition state.
- Issues response requests (state query, address inquiry, data return) to the TX path via a req/ack handshake.

Parameters:
- MY_ADDR, 8'h01, this node's address; 8'hFF is always accepted as broadcast.
- DEF_RATE, 16'd100, reset value of rate register (clk cycles per sample).
- DEF_POINTS, 16'd1024, reset value of point register (samples per acquisition).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- i_cmd_en  in  1  one-cycle pulse; i_func/i_addr valid.
- i_func  in  3  1=START, 2=STOP, 3=DATA_RETURN, 4=ADDR_INQ, 5=STATE_QUERY; others ignored.
- i_addr  in  8  command target address.
- i_rate_conf  in  16  new rate value.
- i_rate_conf_en  in  1  pulse, load rate.
- i_point_conf  in  16  new point value.
- i_point_conf_en  in  1  pulse, load points.
- i_tx_ack  in  1  TX path accepted current request.
- o_sample_tick  out  1  one-cycle sample strobe to ADC engine.
- o_sample_idx  out  16  index of current/last sample.
- o_done  out  1  one-cycle pulse, acquisition complete.
- o_state  out  2  0=IDLE, 1=RUN, 2=DONE.
- o_tx_req  out  1  response request, held until ack.
- o_tx_type  out  3  function code being answered.
- o_tx_arg  out  16  response payload.
- o_err  out  1  one-cycle pulse, command/config rejected.

Behaviour:
- Reset: state IDLE; rate_reg=DEF_RATE; point_reg=DEF_POINTS; rate counter 0; all outputs 0.
- Address filter: command accepted only if i_addr==MY_ADDR or 8'hFF; otherwise silently dropped, no o_err.
- Config load:
  - Accepted only in IDLE/DONE and when value != 0; takes effect the next cycle.
  - Zero value or RUN state: register unchanged, o_err pulses next cycle.
  - Both conf_en pulses in the same cycle: each is evaluated independently.
- START:
  - In IDLE/DONE: enter RUN; rate counter=0, sample count=0.
  - Rate counter increments each cycle; when it equals rate_reg-1 it wraps to 0 and o_sample_tick pulses, so the first tick occurs rate_reg cycles after the START cycle.
  - On each tick: o_sample_idx=count, then count++.
  - On tick with count==point_reg-1: o_done pulses in the same cycle; state becomes DONE next cycle.
  - START in RUN: o_err, ignored.
- STOP:
  - In RUN: state becomes IDLE next cycle; a tick coincident with STOP is suppressed; o_sample_idx is retained.
  - STOP in IDLE/DONE: no-op.
- Response requests (DATA_RETURN, ADDR_INQ, STATE_QUERY):
  - On accept, next cycle: o_tx_req=1, o_tx_type=i_func; o_tx_arg fixed until ack.
    - ADDR_INQ: o_tx_arg={8'h00,MY_ADDR}.
    - STATE_QUERY: o_tx_arg={14'b0,o_state} sampled at accept.
    - DATA_RETURN: o_tx_arg=point_reg.
  - DATA_RETURN accepted only in DONE; otherwise o_err.
  - o_tx_req drops the cycle after i_tx_ack=1; DATA_RETURN ack moves DONE->IDLE.
  - New response command while o_tx_req=1 and no ack that cycle: o_err, dropped. Same-cycle ack + new command: new request accepted, o_tx_req stays 1.
  - Acquisition in RUN continues unaffected by TX handshakes.
- Reset mid-operation: immediate return to reset values; pending tx request cancelled.
- Widths: counters 16-bit unsigned; point_reg=65535 is legal; no overflow beyond point_reg-1.

Optional Feature:
- Macro: ACQ_CTRL_CONTINUOUS_EN.
- Defined: on reaching point_reg samples, o_done pulses, count wraps to 0 and RUN continues; only STOP or reset exits RUN. DONE is reached only via... never (DATA_RETURN always o_err).
- Undefined: single-shot behaviour above.

Test Plan:
- Reset, STATE_QUERY addr 8'h01 -> o_tx_req=1, type=5, arg=0; ack -> req=0 next cycle.
- rate_conf=4, point_conf=3, START -> ticks at cycles 4, 8, 12 after START with idx 0, 1, 2; o_done on 3rd tick; o_state=2.
- In DONE, DATA_RETURN -> tx_req type=3, arg=3; ack -> o_state=0.
- During RUN, rate_conf=10 -> o_err pulse, ticks keep 4-cycle spacing; STOP coincident with tick -> no tick, state IDLE, idx holds last value.
- Command addr 8'h22 -> nothing; addr 8'hFF ADDR_INQ -> arg=16'h0001; second ADDR_INQ before ack -> o_err.
- rate_conf=0 -> o_err, rate unchanged; async reset asserted mid-RUN -> all outputs 0 immediately.
